mem_cfg_master: RTL and testbench
=================================

MEM_CFG_MASTER -- requirements
Module: mem_cfg_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, maximum ACCESS cycles without mem_ack before abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req_valid  input  1  command request present.
REQ-005 req_ready  output  1  block can accept a command.
REQ-006 req_wr  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  8  target register address.
REQ-008 req_wdata  input  8  write data (ignored for reads).
REQ-009 rsp_valid  output  1  one-cycle completion strobe.
REQ-010 rsp_rdata  output  8  read data; 0 for writes and errors.
REQ-011 rsp_err  output  1  transaction aborted by timeout.
REQ-012 mem_sel_en  output  1  memory interface enable.
REQ-013 mem_addr  output  8  memory register address.
REQ-014 mem_wr_data  output  8  memory write data.
REQ-015 mem_wr_rd_s  output  1  1 = write, 0 = read.
REQ-016 mem_rd_data  input  8  read data from responder, valid with mem_ack.
REQ-017 mem_ack  input  1  responder acknowledge.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; all outputs registered.
REQ-019 IDLE: req_ready=1; a handshake (req_valid & req_ready at an edge) latches req_wr/addr/wdata and moves to ACCESS; req_ready=0 from that edge.
REQ-020 ACCESS: mem_sel_en=1 with mem_addr, mem_wr_rd_s and mem_wr_data (0 for reads) held constant for the whole state.
REQ-021 First edge in ACCESS with mem_ack=1 completes: latch mem_rd_data for reads (0 for writes) into rsp_rdata, move to RESP, mem_sel_en and all mem_* outputs drop to 0 at that edge.
REQ-022 Minimum latency: handshake at edge E0, mem_sel_en high after E0, mem_ack at E1 -> rsp_valid high during E1..E2, req_ready high after E2.
REQ-023 RESP: rsp_valid=1 for exactly one cycle, then IDLE; rsp_rdata/rsp_err hold until next completion.
REQ-024 mem_ack outside ACCESS is ignored; req_valid while req_ready=0 is ignored and never queued.
REQ-025 mem_addr, mem_wr_data, mem_wr_rd_s are 0 whenever mem_sel_en=0.

Reset
REQ-026 rst high forces IDLE immediately; req_ready, rsp_valid, rsp_err, rsp_rdata, mem_sel_en, mem_addr, mem_wr_data, mem_wr_rd_s all 0.
REQ-027 req_ready rises at the first clk edge after rst deasserts.
REQ-028 rst asserted mid-transaction discards it: no rsp_valid is ever produced for it.

Configuration
REQ-029 Macro MEM_CFG_TIMEOUT_EN defined: ACCESS cycle counter (8 bits, cleared on entry) aborts when TIMEOUT_CYCLES edges pass without mem_ack -> mem_sel_en drops, RESP with rsp_err=1, rsp_rdata=0.
REQ-030 With MEM_CFG_TIMEOUT_EN: mem_ack and timeout on the same edge -> ack wins, rsp_err=0.
REQ-031 Without MEM_CFG_TIMEOUT_EN: no counter, ACCESS waits indefinitely, rsp_err constant 0.

Verification
REQ-032 Write addr 0x12 data 0xA5, mem_ack on first ACCESS edge -> mem_wr_rd_s=1, mem_wr_data=0xA5 for 1 cycle; rsp_valid one cycle, rsp_err=0, rsp_rdata=0x00.
REQ-033 Read addr 0x40, mem_ack after 3 cycles with mem_rd_data=0x3C -> mem_sel_en high 4 cycles, mem_wr_data=0; rsp_rdata=0x3C.
REQ-034 Back-to-back req_valid held high for two writes -> second accepted only after RESP; mem_sel_en low at least 2 cycles between transactions.
REQ-035 MEM_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=4, no mem_ack -> mem_sel_en high exactly 4 cycles, rsp_valid with rsp_err=1, rsp_rdata=0; same with ack on 4th edge -> rsp_err=0.
REQ-036 rst pulsed 2 cycles into ACCESS -> all outputs 0 asynchronously, no rsp_valid, req_ready=1 one edge after release.
REQ-037 Spurious mem_ack in IDLE with mem_rd_data=0xFF -> no state change, rsp_valid stays 0.

Source files
------------

// File: rtl/mem_cfg_master.sv
// mem_cfg_master: single-outstanding command master for a register-style
// memory interface. Accepts one read/write command, drives it onto the
// mem_* bus until the responder acknowledges, then emits a one-cycle
// completion strobe. Every output comes straight from a flop.
//
// Optional feature: define MEM_CFG_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES clock edges without mem_ack. The abort completes with
// rsp_err=1 and rsp_rdata=0. Without the macro the access waits forever
// and rsp_err stays 0.

module mem_cfg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       mem_sel_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wr_data,
  output logic       mem_wr_rd_s,
  input  logic [7:0] mem_rd_data,
  input  logic       mem_ack
);

  // The timeout counter is 8 bits wide, so only 1..255 can be honoured.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_cfg_master: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       req_ready_nxt;
  logic       rsp_valid_nxt;
  logic [7:0] rsp_rdata_nxt;
  logic       rsp_err_nxt;
  logic       mem_sel_en_nxt;
  logic [7:0] mem_addr_nxt;
  logic [7:0] mem_wr_data_nxt;
  logic       mem_wr_rd_s_nxt;

  logic       accept;   // command handshake at this edge
  logic       expired;  // access aborts at this edge (ack not seen)
  logic       finish;   // access leaves ACCESS at this edge

  // req_ready is low during the first cycle after reset even though the
  // state is already IDLE, so the handshake must use the flop itself.
  assign accept = req_valid && req_ready;
  assign finish = (state == ACCESS) && (mem_ack || expired);

`ifdef MEM_CFG_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] access_cnt;  // ACCESS edges already passed without ack

  // Access cycle counter: cleared when a command is accepted, counts each ACCESS edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      access_cnt <= 8'd0;
    end else if (accept) begin
      access_cnt <= 8'd0;
    end else if (state == ACCESS) begin
      access_cnt <= access_cnt + 8'd1;
    end
  end

  // An ack on the final allowed edge still wins over the abort.
  assign expired = (state == ACCESS) && !mem_ack && (access_cnt == TIMEOUT_LAST);
`else
  assign expired = 1'b0;
`endif

  // State and registered outputs.
  // NOTE: flops are updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'd0;
      rsp_err     <= 1'b0;
      mem_sel_en  <= 1'b0;
      mem_addr    <= 8'd0;
      mem_wr_data <= 8'd0;
      mem_wr_rd_s <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_ready   <= req_ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      mem_sel_en  <= mem_sel_en_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wr_data <= mem_wr_data_nxt;
      mem_wr_rd_s <= mem_wr_rd_s_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  if (finish) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would infer a latch.
    req_ready_nxt   = 1'b0;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    mem_sel_en_nxt  = 1'b0;
    mem_addr_nxt    = 8'd0;
    mem_wr_data_nxt = 8'd0;
    mem_wr_rd_s_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          mem_sel_en_nxt  = 1'b1;
          mem_addr_nxt    = req_addr;
          mem_wr_rd_s_nxt = req_wr;
          mem_wr_data_nxt = req_wr ? req_wdata : 8'd0;
        end else begin
          req_ready_nxt = 1'b1;
        end
      end
      ACCESS: begin
        if (finish) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = !mem_ack;
          rsp_rdata_nxt = (mem_ack && !mem_wr_rd_s) ? mem_rd_data : 8'd0;
        end else begin
          mem_sel_en_nxt  = 1'b1;
          mem_addr_nxt    = mem_addr;
          mem_wr_rd_s_nxt = mem_wr_rd_s;
          mem_wr_data_nxt = mem_wr_data;
        end
      end
      RESP: begin
        req_ready_nxt = 1'b1;
      end
      default: begin
        req_ready_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_cfg_master.sv
// Self-checking bench for mem_cfg_master. Inputs change and outputs are
// sampled on the falling clock edge. Expected values come from a
// transaction-level model: a command with an ack delay of d cycles keeps
// mem_sel_en high for d+1 cycles (or TIMEOUT_CYCLES when the timeout
// feature is built in and d reaches it), then completes with read data,
// zero or an error as the rules dictate.

module tb_mem_cfg_master;

  localparam int unsigned T = 4;

`ifdef MEM_CFG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       mem_sel_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic       mem_wr_rd_s;
  logic [7:0] mem_rd_data;
  logic       mem_ack;

  int n_asserts = 0;
  int n_fails   = 0;

  // last completed response, tracked by the model
  logic [7:0] last_rdata = 8'h00;
  logic       last_err   = 1'b0;

  always #5 clk = ~clk;

  mem_cfg_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_sel_en  (mem_sel_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_rd_s (mem_wr_rd_s),
    .mem_rd_data (mem_rd_data),
    .mem_ack     (mem_ack)
  );

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_v(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_n(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mem bus must be fully zero whenever it is not selected
  task automatic check_bus_idle(input string tag);
    check_b({tag, "_sel"},   mem_sel_en,  1'b0);
    check_v({tag, "_addr"},  mem_addr,    8'h00);
    check_v({tag, "_wdata"}, mem_wr_data, 8'h00);
    check_b({tag, "_wrrd"},  mem_wr_rd_s, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_bus_idle(tag);
    check_b({tag, "_ready"}, req_ready, 1'b0);
    check_b({tag, "_rspv"},  rsp_valid, 1'b0);
    check_b({tag, "_err"},   rsp_err,   1'b0);
    check_v({tag, "_rdata"}, rsp_rdata, 8'h00);
  endtask

  // One complete transaction; called at a falling edge with the DUT idle.
  // delay = number of ACCESS edges before the one carrying mem_ack.
  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input int delay, input logic [7:0] rd);
    logic       exp_err;
    int         exp_cyc;
    logic [7:0] exp_wdata;
    logic [7:0] exp_rdata;
    int         cyc;
    exp_err   = TO_EN && (delay >= int'(T));
    exp_cyc   = exp_err ? int'(T) : delay + 1;
    exp_wdata = wr ? wdata : 8'h00;
    exp_rdata = (wr || exp_err) ? 8'h00 : rd;

    check_b("txn_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    // scramble request fields: the latched command must not follow them
    req_valid = 1'b0;
    req_wr    = 1'($urandom_range(0, 1));
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);
    cyc = 0;
    while (mem_sel_en === 1'b1 && cyc < 300) begin
      check_v("acc_addr",  mem_addr,    addr);
      check_b("acc_wrrd",  mem_wr_rd_s, wr);
      check_v("acc_wdata", mem_wr_data, exp_wdata);
      check_b("acc_ready", req_ready,   1'b0);
      check_b("acc_rspv",  rsp_valid,   1'b0);
      mem_ack     = (cyc == delay);
      mem_rd_data = mem_ack ? rd : 8'($urandom);
      req_valid   = 1'($urandom_range(0, 1));  // must be ignored while busy
      cyc++;
      @(negedge clk);
    end
    mem_ack     = 1'b0;
    mem_rd_data = 8'($urandom);
    req_valid   = 1'b0;
    check_n("sel_cycles", cyc, exp_cyc);
    check_b("rsp_valid_hi", rsp_valid, 1'b1);
    check_v("rsp_rdata",    rsp_rdata, exp_rdata);
    check_b("rsp_err",      rsp_err,   exp_err);
    check_b("rsp_ready_lo", req_ready, 1'b0);
    check_bus_idle("rsp_bus");
    last_rdata = exp_rdata;
    last_err   = exp_err;
    @(negedge clk);
    check_b("post_rspv",  rsp_valid, 1'b0);
    check_b("post_ready", req_ready, 1'b1);
    check_v("hold_rdata", rsp_rdata, last_rdata);
    check_b("hold_err",   rsp_err,   last_err);
    check_bus_idle("post_bus");
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_wr      = 1'b0;
    req_addr    = 8'h00;
    req_wdata   = 8'h00;
    mem_rd_data = 8'h00;
    mem_ack     = 1'b0;

    // reset values before any clock edge
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_b("ready_before_edge", req_ready, 1'b0);
    @(negedge clk);
    check_b("ready_first_edge", req_ready, 1'b1);

    // spurious ack while idle
    mem_ack     = 1'b1;
    mem_rd_data = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      check_b("spur_rspv",  rsp_valid, 1'b0);
      check_b("spur_ready", req_ready, 1'b1);
      check_v("spur_rdata", rsp_rdata, 8'h00);
      check_bus_idle("spur_bus");
    end
    mem_ack = 1'b0;

    // write with immediate ack, then read with three wait cycles
    run_txn(1'b1, 8'h12, 8'hA5, 0, 8'h77);
    run_txn(1'b0, 8'h40, 8'h99, 3, 8'h3C);

    // req_valid held high across two writes
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 8'h81;
    req_wdata = 8'h11;
    @(negedge clk);
    check_b("b2b_sel1",  mem_sel_en,  1'b1);
    check_v("b2b_addr1", mem_addr,    8'h81);
    check_v("b2b_data1", mem_wr_data, 8'h11);
    req_addr  = 8'h82;
    req_wdata = 8'h22;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_b("b2b_rspv1", rsp_valid,  1'b1);
    check_b("b2b_gap1",  mem_sel_en, 1'b0);
    @(negedge clk);
    check_b("b2b_gap2",  mem_sel_en, 1'b0);
    check_b("b2b_ready", req_ready,  1'b1);
    @(negedge clk);
    check_b("b2b_sel2",   mem_sel_en,  1'b1);
    check_v("b2b_addr2",  mem_addr,    8'h82);
    check_v("b2b_data2",  mem_wr_data, 8'h22);
    check_b("b2b_ready2", req_ready,   1'b0);
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_b("b2b_rspv2", rsp_valid, 1'b1);
    @(negedge clk);
    check_b("b2b_idle", req_ready, 1'b1);

`ifdef MEM_CFG_TIMEOUT_EN
    // no ack at all -> abort after T cycles; ack on the T-th edge -> success
    run_txn(1'b0, 8'h55, 8'h00, 20, 8'h99);
    run_txn(1'b0, 8'h56, 8'h00, int'(T) - 1, 8'h77);
    run_txn(1'b1, 8'h57, 8'hC3, int'(T), 8'h00);
`else
    // long wait: access must stay open and finish without error
    run_txn(1'b0, 8'h33, 8'h00, 40, 8'h5A);
`endif

    // reset two cycles into ACCESS discards the transaction
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 8'h21;
    @(negedge clk);
    req_valid = 1'b0;
    check_b("rst_mid_sel", mem_sel_en, 1'b1);
    @(negedge clk);
    #1;
    rst     = 1'b1;
    mem_ack = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_b("rst_rel_ready0", req_ready, 1'b0);
    @(negedge clk);
    check_b("rst_rel_ready1", req_ready, 1'b1);
    mem_ack = 1'b0;
    repeat (3) begin
      check_b("rst_no_rsp", rsp_valid, 1'b0);
      check_bus_idle("rst_bus");
      @(negedge clk);
    end
    last_rdata = 8'h00;
    last_err   = 1'b0;

    // randomized transactions against the model
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, T + 3)), 8'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_b("gap_ready", req_ready, 1'b1);
        check_b("gap_rspv",  rsp_valid, 1'b0);
        check_v("gap_rdata", rsp_rdata, last_rdata);
        check_b("gap_err",   rsp_err,   last_err);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  // Global time limit so a stuck run still terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
